// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control stage: ALUop groups, opcode patterns,
// 4-bit ALU operation codes and the handshake FSM state encoding.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_LS  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // R-type opcodes, full 11 bits
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LSL = 11'b11010011011;
  localparam logic [10:0] OP_LSR = 11'b11010011010;
  localparam logic [10:0] OP_MUL = 11'b10011011000;

  // I-type opcodes carry an immediate bit in the LSB, so only the top 10 bits match
  localparam logic [9:0] OP_ADDI = 10'b1001000100;
  localparam logic [9:0] OP_SUBI = 10'b1101000100;
  localparam logic [9:0] OP_ANDI = 10'b1001001000;
  localparam logic [9:0] OP_ORRI = 10'b1011001000;

  localparam logic [3:0] ALUCTRL_AND   = 4'b0000;
  localparam logic [3:0] ALUCTRL_ORR   = 4'b0001;
  localparam logic [3:0] ALUCTRL_ADD   = 4'b0010;
  localparam logic [3:0] ALUCTRL_LSL   = 4'b0011;
  localparam logic [3:0] ALUCTRL_LSR   = 4'b0100;
  localparam logic [3:0] ALUCTRL_MUL   = 4'b0101;
  localparam logic [3:0] ALUCTRL_SUB   = 4'b0110;
  localparam logic [3:0] ALUCTRL_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MULW = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUop/opcode decode table: ALU operation code, illegal flag
// and a MUL marker used by the stage to start its latency count.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0]  aluop,
  input  logic [10:0] op,
  output logic [3:0]  ctrl,
  output logic        illegal,
  output logic        is_mul
);

  // Table lookup; unknown R/I opcodes fall back to ADD and raise illegal
  always_comb begin
    ctrl    = ALUCTRL_ADD;
    illegal = 1'b0;
    is_mul  = 1'b0;
    case (aluop)
      ALUOP_LS:  ctrl = ALUCTRL_ADD;
      ALUOP_CBZ: ctrl = ALUCTRL_PASSB;
      ALUOP_R: begin
        case (op)
          OP_ADD:  ctrl = ALUCTRL_ADD;
          OP_SUB:  ctrl = ALUCTRL_SUB;
          OP_AND:  ctrl = ALUCTRL_AND;
          OP_ORR:  ctrl = ALUCTRL_ORR;
          OP_LSL:  ctrl = ALUCTRL_LSL;
          OP_LSR:  ctrl = ALUCTRL_LSR;
          OP_MUL: begin
            ctrl   = ALUCTRL_MUL;
            is_mul = 1'b1;
          end
          default: begin
            ctrl    = ALUCTRL_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        case (op[10:1])
          OP_ADDI: ctrl = ALUCTRL_ADD;
          OP_SUBI: ctrl = ALUCTRL_SUB;
          OP_ANDI: ctrl = ALUCTRL_AND;
          OP_ORRI: ctrl = ALUCTRL_ORR;
          default: begin
            ctrl    = ALUCTRL_ADD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU control stage at the ID/EX boundary. Decodes ALUop/Opcode,
// holds the result under a valid/ready handshake and stretches MUL entries
// over a programmable latency before presenting them to EX.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int CTRL_W   = 4,
  parameter int MUL_LAT  = 4
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          ALUop,
  input  logic [OPCODE_W-1:0] Opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   ALUCtrl,
  output logic                illegal,
  output logic                busy
);

  localparam int               CNT_W     = $clog2(MUL_LAT + 1);
  localparam bit               MUL_MULTI = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [10:0]      op_p0;
  logic [3:0]       dec_ctrl_p0;
  logic             dec_ill_p0;
  logic             dec_mul_p0;

  state_t           state_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             vld_p1;
  logic             busy_p1;
  logic             ill_p1;
  logic [3:0]       ctrl_p1;

  logic             accept;
  logic             consume;

  // ---- p0: combinational decode of the incoming entry ----
  assign op_p0 = Opcode[OPCODE_W-1 -: 11];

  alu_ctrl_decode u_decode (
    .aluop   (ALUop),
    .op      (op_p0),
    .ctrl    (dec_ctrl_p0),
    .illegal (dec_ill_p0),
    .is_mul  (dec_mul_p0)
  );

  assign in_ready = (state_p1 == ST_IDLE) | ((state_p1 == ST_HOLD) & out_ready);
  assign accept   = in_valid & in_ready;
  assign consume  = vld_p1 & out_ready;

  // ---- p1: handshake FSM, MUL latency counter and held outputs ----
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_p1 <= ST_IDLE;
      cnt_p1   <= '0;
      vld_p1   <= 1'b0;
      busy_p1  <= 1'b0;
      ill_p1   <= 1'b0;
      ctrl_p1  <= '0;
    end else if (flush) begin
      state_p1 <= ST_IDLE;
      cnt_p1   <= '0;
      vld_p1   <= 1'b0;
      busy_p1  <= 1'b0;
    end else begin
      case (state_p1)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            ctrl_p1 <= dec_ctrl_p0;
            ill_p1  <= dec_ill_p0;
            if (dec_mul_p0 && MUL_MULTI) begin
              state_p1 <= ST_MULW;
              cnt_p1   <= CNT_LOAD;
              vld_p1   <= 1'b0;
              busy_p1  <= 1'b1;
            end else begin
              state_p1 <= ST_HOLD;
              cnt_p1   <= '0;
              vld_p1   <= 1'b1;
              busy_p1  <= 1'b0;
            end
          end else if (state_p1 == ST_HOLD && consume) begin
            state_p1 <= ST_IDLE;
            vld_p1   <= 1'b0;
          end
        end
        ST_MULW: begin
          if (cnt_p1 == CNT_ONE) begin
            state_p1 <= ST_HOLD;
            cnt_p1   <= '0;
            vld_p1   <= 1'b1;
            busy_p1  <= 1'b0;
          end else begin
            cnt_p1 <= cnt_p1 - CNT_ONE;
          end
        end
        default: begin
          state_p1 <= ST_IDLE;
          cnt_p1   <= '0;
          vld_p1   <= 1'b0;
          busy_p1  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign busy      = busy_p1;
  assign illegal   = ill_p1;
  assign ALUCtrl   = CTRL_W'(ctrl_p1);

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode table streamed back-to-back,
// then hand-written MUL latency, stall, flush and reset sequences.
module tb_alu_ctrl_stage;

  localparam int OPCODE_W = 11;
  localparam int CTRL_W   = 4;
  localparam int MUL_LAT  = 4;

  logic                CLK;
  logic                Reset;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          ALUop;
  logic [OPCODE_W-1:0] Opcode;
  logic                out_valid;
  logic                out_ready;
  logic [CTRL_W-1:0]   ALUCtrl;
  logic                illegal;
  logic                busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  aluop;
    logic [10:0] opcode;
    logic [3:0]  ctrl;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  alu_ctrl_stage #(
    .OPCODE_W (OPCODE_W),
    .CTRL_W   (CTRL_W),
    .MUL_LAT  (MUL_LAT)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUop     (ALUop),
    .Opcode    (Opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUCtrl   (ALUCtrl),
    .illegal   (illegal),
    .busy      (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [10:0] o);
    in_valid = v;
    ALUop    = a;
    Opcode   = o;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 11'b10001011000, 4'b0010, 1'b0}; // ADD
    vecs[1]  = '{2'b10, 11'b11001011000, 4'b0110, 1'b0}; // SUB
    vecs[2]  = '{2'b10, 11'b10001010000, 4'b0000, 1'b0}; // AND
    vecs[3]  = '{2'b10, 11'b10101010000, 4'b0001, 1'b0}; // ORR
    vecs[4]  = '{2'b10, 11'b11010011011, 4'b0011, 1'b0}; // LSL
    vecs[5]  = '{2'b10, 11'b11010011010, 4'b0100, 1'b0}; // LSR
    vecs[6]  = '{2'b11, 11'b10010001001, 4'b0010, 1'b0}; // ADDI
    vecs[7]  = '{2'b11, 11'b11010001000, 4'b0110, 1'b0}; // SUBI
    vecs[8]  = '{2'b11, 11'b10010010001, 4'b0000, 1'b0}; // ANDI
    vecs[9]  = '{2'b11, 11'b10110010000, 4'b0001, 1'b0}; // ORRI
    vecs[10] = '{2'b00, 11'b11111111111, 4'b0010, 1'b0}; // load/store
    vecs[11] = '{2'b01, 11'b10001011000, 4'b0111, 1'b0}; // CBZ
    vecs[12] = '{2'b10, 11'b11111111111, 4'b0010, 1'b1}; // bad R-type
    vecs[13] = '{2'b10, 11'b10010001000, 4'b0010, 1'b1}; // I-type pattern under R
    vecs[14] = '{2'b11, 11'b11111111111, 4'b0010, 1'b1}; // bad I-type

    Reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 11'b10001011000);

    // reset held two cycles with in_valid high
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ctrl", 32'(ALUCtrl), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    Reset = 1'b0;
    drive(1'b0, 2'b00, 11'd0);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // table streamed back-to-back with out_ready high
    for (int i = 0; i < 15; i++) begin
      if (i > 0) begin
        chk($sformatf("vec%0d_valid", i - 1), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_ctrl", i - 1), 32'(ALUCtrl), 32'(vecs[i-1].ctrl));
        chk($sformatf("vec%0d_ill", i - 1), 32'(illegal), 32'(vecs[i-1].ill));
      end
      drive(1'b1, vecs[i].aluop, vecs[i].opcode);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge CLK);
    end
    chk("vec14_valid", 32'(out_valid), 32'd1);
    chk("vec14_ctrl", 32'(ALUCtrl), 32'(vecs[14].ctrl));
    chk("vec14_ill", 32'(illegal), 32'(vecs[14].ill));
    drive(1'b0, 2'b00, 11'd0);
    @(negedge CLK);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // MUL: busy for MUL_LAT-1 cycles, then valid; a waiting ADD issues back-to-back
    drive(1'b1, 2'b10, 11'b10011011000);
    @(negedge CLK);
    drive(1'b1, 2'b10, 11'b10001011000);
    for (int k = 1; k < MUL_LAT; k++) begin
      #1;
      chk($sformatf("mul_busy_t%0d", k), 32'(busy), 32'd1);
      chk($sformatf("mul_in_ready_t%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("mul_out_valid_t%0d", k), 32'(out_valid), 32'd0);
      @(negedge CLK);
    end
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_done_ctrl", 32'(ALUCtrl), 32'b0101);
    chk("mul_done_busy", 32'(busy), 32'd0);
    chk("mul_done_in_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    chk("mul_next_valid", 32'(out_valid), 32'd1);
    chk("mul_next_ctrl", 32'(ALUCtrl), 32'b0010);
    drive(1'b0, 2'b00, 11'd0);
    @(negedge CLK);
    chk("mul_drain_valid", 32'(out_valid), 32'd0);

    // stall in HOLD for 3 cycles, then release with a waiting SUB
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 11'b10101010000);
    @(negedge CLK);
    drive(1'b1, 2'b10, 11'b11001011000);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_ctrl", k), 32'(ALUCtrl), 32'b0001);
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      @(negedge CLK);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    chk("release_next_valid", 32'(out_valid), 32'd1);
    chk("release_next_ctrl", 32'(ALUCtrl), 32'b0110);
    drive(1'b0, 2'b00, 11'd0);
    @(negedge CLK);
    chk("release_drain_valid", 32'(out_valid), 32'd0);

    // flush during MULW: nothing emitted afterwards
    drive(1'b1, 2'b10, 11'b10011011000);
    @(negedge CLK);
    drive(1'b0, 2'b00, 11'd0);
    chk("flushw_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    chk("flushw_busy", 32'(busy), 32'd0);
    chk("flushw_valid", 32'(out_valid), 32'd0);
    chk("flushw_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < MUL_LAT + 1; k++) begin
      @(negedge CLK);
      chk($sformatf("flushw_quiet%0d", k), 32'(out_valid | busy), 32'd0);
    end

    // flush in HOLD drops the same-cycle accept
    drive(1'b1, 2'b10, 11'b11010011011);
    @(negedge CLK);
    chk("flushh_valid_before", 32'(out_valid), 32'd1);
    drive(1'b1, 2'b10, 11'b11001011000);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    drive(1'b0, 2'b00, 11'd0);
    chk("flushh_valid", 32'(out_valid), 32'd0);
    @(negedge CLK);
    chk("flushh_quiet", 32'(out_valid), 32'd0);

    // reset mid-MUL: MULW abandoned, nothing emitted
    drive(1'b1, 2'b10, 11'b10011011000);
    @(negedge CLK);
    drive(1'b0, 2'b00, 11'd0);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    chk("rstmul_busy", 32'(busy), 32'd0);
    chk("rstmul_ctrl", 32'(ALUCtrl), 32'd0);
    for (int k = 0; k < MUL_LAT + 1; k++) begin
      @(negedge CLK);
      chk($sformatf("rstmul_quiet%0d", k), 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
